shot_resolver: RTL
==================

# shot_resolver

Resolves a player's shot against the hidden ship map and keeps the board's hit/miss record. Sits directly downstream of `grid_controller`: it takes that block's one-hot 36-bit cursor grid plus a fire request, and decides hit, miss, repeat or invalid. It updates the hit and miss grids and the shot/hit counters, and flags game over when every ship cell has been hit. Its outputs feed the display and score logic.

## Interface
Parameters
- `CELLS`, 36: board cells (6x6), bit index = y*6 + x, same mapping as the cursor grid.
- `CW`, 6: width of the shot and hit counters.

Ports
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `grid` in CELLS: cursor grid from `grid_controller`; exactly one bit set when valid.
- `ships` in CELLS: ship occupancy map, 1 = ship cell; must be held stable while `busy`=1.
- `fire` in 1: shot request, level-sampled; accepted only on an edge where state=IDLE and `game_over`=0.
- `clear` in 1: synchronous new-game clear.
- `busy` out 1: high while a shot is being resolved (CHECK, UPDATE).
- `hits` out CELLS: cells shot and found occupied.
- `misses` out CELLS: cells shot and found empty.
- `shot_count` out CW: accepted hit+miss shots.
- `hit_count` out CW: hits so far.
- `result_valid` out 1: one-cycle strobe when a shot is resolved.
- `result_code` out 2: 00 miss, 01 hit, 10 repeat, 11 invalid; valid only with `result_valid`.
- `game_over` out 1: sticky, set when (hits & ships) == ships and ships != 0.

## Operation
- Reset (async) and `clear` (sync) do the same thing:
  - state goes to IDLE.
  - `hits`, `misses`, `shot_count`, `hit_count`, `result_valid`, `result_code`, `game_over` and `busy` all go to 0.
  - internal latches go to 0.
- `clear` has priority over everything except reset. It aborts a shot that is in flight, and no `result_valid` is emitted for that shot.
- State machine with three states.
- **IDLE**:
  - On `fire`=1 and `game_over`=0, latch `grid` into cursor_q and `ships` into ships_q, then go to CHECK.
  - Otherwise stay in IDLE.
  - `fire` while `game_over`=1 is ignored, with no result.
- **CHECK**:
  - Compute the one-hot-to-index encoding of cursor_q into a 6-bit index.
  - Classify the shot:
    - invalid: cursor_q is zero or has more than one bit set.
    - repeat: the cell is already set in `hits` or `misses`.
    - hit: ships_q bit is 1.
    - miss: otherwise.
  - Register the index and the code, then go to UPDATE.
- **UPDATE**:
  - Hit: set that bit in `hits`; increment `shot_count` and `hit_count`.
  - Miss: set that bit in `misses`; increment `shot_count`.
  - Repeat or invalid: no grid or counter change.
  - Drive `result_valid`=1 with the code, then go to IDLE.
  - If the post-update (hits & ships_q) == ships_q and ships_q != 0, set `game_over` in the same edge as `result_valid`.
- Counters saturate at 2^CW-1; they cannot exceed 36 in legal play.
- `hits` and `misses` are always disjoint. A cell is written at most once per game.
- `fire` held high across several cycles produces one shot per return to IDLE. A repeat shot on the same cell reports code 10.

## Timing
- `fire` sampled high at edge k (state IDLE):
  - busy=1 after edge k and after edge k+1.
  - `result_valid`=1 for exactly the cycle after edge k+2.
  - busy=0 after edge k+2.
- Next fire acceptance is at edge k+3 at the earliest. Shot throughput is one per 3 cycles.
- `fire` during CHECK or UPDATE is ignored, not queued.
- `grid` changes after edge k do not affect the shot in flight.
- `ships` changes while busy=1 are likewise ignored, because the map is latched.
- `game_over` rises together with the `result_valid` of the final hit and stays high until reset or `clear`.
- Reset asserted mid-shot: all outputs are 0 immediately (asynchronous), with no strobe.

## Test plan
- After reset, set ships=36'h3 and grid=36'h1, then pulse fire: two cycles later result_valid=1, code=01, hits=36'h1, shot_count=1, hit_count=1, game_over=0.
- Fire at grid=36'h4 (cell 2, empty): code=00, misses=36'h4, shot_count=2. Fire again at 36'h4: code=10, counts unchanged.
- Fire at grid=36'h2: code=01, hits=36'h3, game_over=1 in the same cycle as result_valid. A further fire produces no result_valid and busy stays 0.
- Invalid cursors: grid=0 and grid=36'h5 each give code=11 with no state change. Hold fire high for 9 cycles: exactly 3 result_valid strobes, spaced 3 cycles apart.
- Change grid and ships during busy: the result reflects the values latched at the fire edge. Pulse fire again in the CHECK cycle: it is ignored.
- Assert clear in the CHECK cycle: no result_valid, and all grids and counters return to 0. Assert reset asynchronously mid-UPDATE: every output reads 0 before the next clock edge.

Source files
------------

// File: rtl/shot_resolver.sv
// shot_resolver: classifies a fire request against the latched ship map
// and maintains the hit/miss record, shot counters and game-over flag.
module shot_resolver #(
  parameter int CELLS = 36,
  parameter int CW    = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CELLS-1:0] i_grid,
  input  logic [CELLS-1:0] i_ships,
  input  logic             i_fire,
  input  logic             i_clear,
  output logic             o_busy,
  output logic [CELLS-1:0] o_hits,
  output logic [CELLS-1:0] o_misses,
  output logic [CW-1:0]    o_shot_count,
  output logic [CW-1:0]    o_hit_count,
  output logic             o_result_valid,
  output logic [1:0]       o_result_code,
  output logic             o_game_over
);

  localparam int IW = $clog2(CELLS);

  localparam logic [1:0] C_MISS = 2'b00;
  localparam logic [1:0] C_HIT  = 2'b01;
  localparam logic [1:0] C_REP  = 2'b10;
  localparam logic [1:0] C_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CELLS-1:0] r_cursor;
  logic [CELLS-1:0] r_ships;
  logic [CELLS-1:0] r_hits;
  logic [CELLS-1:0] r_misses;
  logic [IW-1:0]    r_idx;
  logic [1:0]       r_code;
  logic [CW-1:0]    r_shot;
  logic [CW-1:0]    r_hitc;
  logic             r_rv;
  logic [1:0]       r_rc;
  logic             r_go;

  logic             w_accept;
  logic [IW-1:0]    w_idx;
  logic [IW:0]      w_ones;
  logic [1:0]       w_code;
  logic [CELLS-1:0] w_cell;
  logic [CELLS-1:0] w_hits_nx;
  logic [CELLS-1:0] w_miss_nx;
  logic             w_done;
  logic             w_counted;

  assign w_accept = (r_state == S_IDLE) && i_fire && !r_go;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CHECK;
      S_CHECK:  w_next = S_UPDATE;
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_idx  = '0;
    w_ones = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (r_cursor[i]) begin
        w_idx  = IW'(i);
        w_ones = w_ones + (IW+1)'(1);
      end
    end
  end

  // Classification order matters: a malformed cursor is never a repeat.
  always_comb begin
    w_code = C_MISS;
    priority case (1'b1)
      (w_ones != (IW+1)'(1)):              w_code = C_INV;
      (|(r_cursor & (r_hits | r_misses))): w_code = C_REP;
      (|(r_cursor & r_ships)):             w_code = C_HIT;
      default:                             w_code = C_MISS;
    endcase
  end

  assign w_cell    = {{(CELLS-1){1'b0}}, 1'b1} << r_idx;
  assign w_hits_nx = (r_code == C_HIT)  ? (r_hits | w_cell)   : r_hits;
  assign w_miss_nx = (r_code == C_MISS) ? (r_misses | w_cell) : r_misses;
  assign w_done    = ((w_hits_nx & r_ships) == r_ships) && (|r_ships);
  assign w_counted = (r_code == C_HIT) || (r_code == C_MISS);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cursor <= '0;
      r_ships  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_idx    <= '0;
      r_code   <= '0;
      r_shot   <= '0;
      r_hitc   <= '0;
      r_rv     <= 1'b0;
      r_rc     <= '0;
      r_go     <= 1'b0;
    end else if (i_clear) begin
      r_cursor <= '0;
      r_ships  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      r_idx    <= '0;
      r_code   <= '0;
      r_shot   <= '0;
      r_hitc   <= '0;
      r_rv     <= 1'b0;
      r_rc     <= '0;
      r_go     <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      if (w_accept) begin
        r_cursor <= i_grid;
        r_ships  <= i_ships;
      end
      if (r_state == S_CHECK) begin
        r_idx  <= w_idx;
        r_code <= w_code;
      end
      if (r_state == S_UPDATE) begin
        r_rv     <= 1'b1;
        r_rc     <= r_code;
        r_hits   <= w_hits_nx;
        r_misses <= w_miss_nx;
        if (w_counted && (r_shot != '1)) r_shot <= r_shot + CW'(1);
        if ((r_code == C_HIT) && (r_hitc != '1)) r_hitc <= r_hitc + CW'(1);
        if (w_done) r_go <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_hits         = r_hits;
  assign o_misses       = r_misses;
  assign o_shot_count   = r_shot;
  assign o_hit_count    = r_hitc;
  assign o_result_valid = r_rv;
  assign o_result_code  = r_rc;
  assign o_game_over    = r_go;

endmodule
